// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver (majority vote at ticks 7/8/9) feeding a FWFT receive FIFO.
// Parity checking and the PAR state are built only when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 100_000,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          serial_rx,
    input  logic                          clr_err,
    output logic [7:0]                    out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_err,
    output logic                          parity_err,
    output logic                          overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   recv_count
);
    localparam int DIV = CLK_FREQ / (BAUD * 16);
    localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
        STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_rx_fifo: illegal parameter set");
    end

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic          rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
    logic [1:0]    sync_vld_q, sync_vld_d;
    logic          armed_q, armed_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [3:0]    sub_q, sub_d;
    logic [1:0]    samp_q, samp_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   recv_q, recv_d;
    logic          frame_err_q, frame_err_d, overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic          par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

    logic tick, decide, bit_val, stop_dec, pop, full, good, push;

    always_comb begin
        rx_meta_d  = serial_rx;
        rx_s_d     = rx_meta_q;
        sync_vld_d = {sync_vld_q[0], 1'b1};
        armed_d    = armed_q;
        tick       = (tick_cnt_q == TW'(DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        sub_d      = tick ? sub_q + 4'd1 : sub_q;
        samp_d     = samp_q;
        if (tick && sub_q == 4'd7) samp_d[0] = rx_s_q;
        if (tick && sub_q == 4'd8) samp_d[1] = rx_s_q;
        decide     = tick && (sub_q == 4'd9);
        bit_val    = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        stop_dec   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif

        case (state_q)
            S_IDLE: begin
                // Only a high level seen after reset/frame end arms start detection.
                armed_d = armed_q | (sync_vld_q[1] & rx_s_q);
                if (armed_q && !rx_s_q) begin
                    state_d    = S_START;
                    armed_d    = 1'b0;
                    tick_cnt_d = '0;
                    sub_d      = '0;
                    bit_idx_d  = '0;
                    shift_d    = '0;
`ifdef UART_RX_PARITY_EN
                    par_bad_d  = 1'b0;
`endif
                end
            end
            S_START: if (decide) state_d = bit_val ? S_IDLE : S_DATA;
            S_DATA: if (decide) begin
                shift_d[bit_idx_q] = bit_val;
                if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = (PARITY != 0) ? S_PAR : S_STOP;
`else
                    state_d = S_STOP;
`endif
                end else begin
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PAR: if (decide) begin
                par_bad_d = ((^shift_q) ^ bit_val) != (PARITY == 1);
                state_d   = S_STOP;
            end
`endif
            S_STOP: if (decide) begin
                stop_dec = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        pop  = (level_q != '0) && out_ready;
        full = (level_q == LW'(FIFO_DEPTH));
`ifdef UART_RX_PARITY_EN
        good = stop_dec && bit_val && !par_bad_q;
        parity_err_d = (parity_err_q & ~clr_err) | (stop_dec & bit_val & par_bad_q);
`else
        good = stop_dec && bit_val;
`endif
        push        = good && !(full && !pop);
        frame_err_d = (frame_err_q & ~clr_err) | (stop_dec & ~bit_val);
        overrun_d   = (overrun_q & ~clr_err) | (good & full & ~pop);

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = shift_q;
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push) - LW'(pop);
        recv_d   = recv_q + 16'(push);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            sync_vld_q  <= '0;
            armed_q     <= 1'b0;
            tick_cnt_q  <= '0;
            sub_q       <= '0;
            samp_q      <= '0;
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            recv_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
            sync_vld_q  <= sync_vld_d;
            armed_q     <= armed_d;
            tick_cnt_q  <= tick_cnt_d;
            sub_q       <= sub_d;
            samp_q      <= samp_d;
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            recv_q      <= recv_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    assign out_data   = mem_q[rd_ptr_q];
    assign out_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign recv_count = recv_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: 8N1 depth-4 instance, 7-bit instance, and a parity instance
// when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;
    localparam int BIT = 496;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic rst, rst7, rx_a, rx_b, clr_a, rdy_a, rdy_b;
    logic [7:0]  data_a, data_b;
    logic        vld_a, vld_b, fe_a, fe_b, pe_a, pe_b, ov_a, ov_b;
    logic [2:0]  lvl_a;
    logic [4:0]  lvl_b;
    logic [15:0] cnt_a, cnt_b;

    uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .serial_rx(rx_a), .clr_err(clr_a),
        .out_data(data_a), .out_valid(vld_a), .out_ready(rdy_a),
        .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a),
        .fifo_level(lvl_a), .recv_count(cnt_a));

    uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(0),
                   .STOP_BITS(2), .FIFO_DEPTH(16)) dut7 (
        .clk(clk), .rst(rst7), .serial_rx(rx_b), .clr_err(1'b0),
        .out_data(data_b), .out_valid(vld_b), .out_ready(rdy_b),
        .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b),
        .fifo_level(lvl_b), .recv_count(cnt_b));

`ifdef UART_RX_PARITY_EN
    logic rx_c;
    logic [7:0]  data_c;
    logic        vld_c, fe_c, pe_c, ov_c;
    logic [2:0]  lvl_c;
    logic [15:0] cnt_c;

    uart_rx_fifo #(.CLK_FREQ(50_000_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2),
                   .STOP_BITS(1), .FIFO_DEPTH(4)) dutp (
        .clk(clk), .rst(rst), .serial_rx(rx_c), .clr_err(1'b0),
        .out_data(data_c), .out_valid(vld_c), .out_ready(1'b0),
        .frame_err(fe_c), .parity_err(pe_c), .overrun(ov_c),
        .fifo_level(lvl_c), .recv_count(cnt_c));
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
`ifdef UART_RX_PARITY_EN
            2: rx_c = v;
`endif
            default: ;
        endcase
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // start, data LSB first, optional parity, one stop bit of the given level, then one idle bit
    task automatic send_frame(input int sel, input logic [7:0] data, input int nbits,
                              input bit has_par, input bit par_bit, input bit stop_val);
        drive(sel, 1'b0); hold(BIT);
        for (int i = 0; i < nbits; i++) begin
            drive(sel, data[i]); hold(BIT);
        end
        if (has_par) begin
            drive(sel, par_bit); hold(BIT);
        end
        drive(sel, stop_val); hold(BIT);
        drive(sel, 1'b1); hold(BIT);
    endtask

    task automatic pop_a;
        rdy_a = 1'b1; hold(1);
        rdy_a = 1'b0; hold(2);
    endtask

    initial begin
        rst = 1'b1; rst7 = 1'b1; rx_a = 1'b1; rx_b = 1'b1;
        clr_a = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0;
`ifdef UART_RX_PARITY_EN
        rx_c = 1'b1;
`endif
        hold(3);
        rst = 1'b0; rst7 = 1'b0;
        hold(20);

        check("rst_valid", 32'(vld_a), 32'h0);
        check("rst_level", 32'(lvl_a), 32'h0);
        check("rst_count", 32'(cnt_a), 32'h0);
        check("rst_data",  32'(data_a), 32'h0);
        check("rst_flags", 32'({fe_a, pe_a, ov_a}), 32'h0);

        // T1 basic 8N1
        send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
        check("t1_valid", 32'(vld_a), 32'h1);
        check("t1_data",  32'(data_a), 32'hA5);
        check("t1_count", 32'(cnt_a), 32'h1);
        check("t1_level", 32'(lvl_a), 32'h1);
        check("t1_flags", 32'({fe_a, pe_a, ov_a}), 32'h0);
        pop_a();
        check("t1_drained", 32'(lvl_a), 32'h0);

        // T2 overrun on a depth-4 FIFO
        rst = 1'b1; hold(2); rst = 1'b0; hold(10);
        for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 8, 1'b0, 1'b0, 1'b1);
        check("t2_level",   32'(lvl_a), 32'h4);
        check("t2_overrun", 32'(ov_a), 32'h1);
        check("t2_count",   32'(cnt_a), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            check("t2_pop_data", 32'(data_a), 32'(i));
            pop_a();
        end
        check("t2_empty", 32'(vld_a), 32'h0);
        check("t2_count_after", 32'(cnt_a), 32'h4);

        // T3 framing error, then clr_err
        send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
        check("t3_frame_err", 32'(fe_a), 32'h1);
        check("t3_empty", 32'(lvl_a), 32'h0);
        check("t3_count", 32'(cnt_a), 32'h4);
        clr_a = 1'b1; hold(1); clr_a = 1'b0; hold(2);
        check("t3_cleared", 32'({fe_a, pe_a, ov_a}), 32'h0);

        // T4 200-clk glitch, then a normal frame proves the receiver is idle again
        rx_a = 1'b0; hold(200); rx_a = 1'b1; hold(3 * BIT);
        check("t4_no_push", 32'(lvl_a), 32'h0);
        check("t4_flags", 32'({fe_a, pe_a, ov_a}), 32'h0);
        send_frame(0, 8'h5A, 8, 1'b0, 1'b0, 1'b1);
        check("t4_next_data", 32'(data_a), 32'h5A);
        check("t4_next_count", 32'(cnt_a), 32'h5);

        // T6 7-bit format with reset mid-frame while the line is low
        rx_b = 1'b0; hold(3 * BIT);
        rst7 = 1'b1; hold(2); rst7 = 1'b0;
        hold(1000);
        check("t6_low_ignored", 32'(lvl_b), 32'h0);
        rx_b = 1'b1; hold(1000);
        send_frame(1, 8'h55, 7, 1'b0, 1'b0, 1'b1);
        check("t6_level", 32'(lvl_b), 32'h1);
        check("t6_data",  32'(data_b), 32'h55);
        check("t6_bit7",  32'(data_b[7]), 32'h0);
        check("t6_count", 32'(cnt_b), 32'h1);
        check("t6_flags", 32'({fe_b, pe_b, ov_b}), 32'h0);

`ifdef UART_RX_PARITY_EN
        // T5 even parity: 0x07 has three ones, so the correct parity bit is 1
        send_frame(2, 8'h07, 8, 1'b1, 1'b1, 1'b1);
        check("t5_good_level", 32'(lvl_c), 32'h1);
        check("t5_good_data",  32'(data_c), 32'h07);
        check("t5_good_perr",  32'(pe_c), 32'h0);
        send_frame(2, 8'h07, 8, 1'b1, 1'b0, 1'b1);
        check("t5_bad_perr",  32'(pe_c), 32'h1);
        check("t5_bad_level", 32'(lvl_c), 32'h1);
        check("t5_bad_count", 32'(cnt_c), 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
